// File: rtl/sccb_responder.sv
// sccb_responder: SCCB write target with a 16-bit register pointer and a
// 16 x 8 register file. Reads are accepted only when SCCB_READ_EN is defined;
// otherwise a read address byte is NACKed.
module sccb_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic        meg25,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic [3:0]  state_test
);

    // The encoding order is what state_test reports.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_ADDRH     = 4'd3,
        ST_ADDRH_ACK = 4'd4,
        ST_ADDRL     = 4'd5,
        ST_ADDRL_ACK = 4'd6,
        ST_WDATA     = 4'd7,
        ST_WDATA_ACK = 4'd8,
        ST_RDATA     = 4'd9,
        ST_RD_ACK    = 4'd10,
        ST_IGNORE    = 4'd11
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic        scl_s;
    logic        sda_s;
    logic        scl_d;
    logic        sda_d;

    logic        start_det;
    logic        stop_det;
    logic        scl_rise;
    logic        scl_fall;

    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        byte_last;
    logic        dev_ok;
    logic        ack_phase;
    logic        sda_oe;
    logic [15:0] ptr;
    logic [7:0]  regfile [16];

    logic        oe_next;
    logic        cnt_clr;
    logic        rx_shift;
    logic        phase_set;
    logic        phase_clr;
    logic        wr_fire;
    logic        ptr_hi_load;
    logic        ptr_lo_load;

`ifdef SCCB_READ_EN
    logic        rw_bit;
    logic [7:0]  tx_sr;
    logic [7:0]  tx_cur;
    logic        tx_bit;
    logic        tx_step;
    logic        ptr_inc;
`else
    logic        unused_regfile;
`endif

    // Open-drain: the pad is only ever pulled low or left floating.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Bring scl/sda into the meg25 domain and keep a one-cycle-old copy.
    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign byte_last = (bit_cnt == 4'd7);
    assign rx_byte   = {rx_sr[6:0], sda_s};

`ifdef SCCB_READ_EN
    assign dev_ok = (rx_byte[7:1] == DEV_ADDR);
    assign tx_cur = regfile[ptr[3:0]];
    assign tx_bit = (bit_cnt == 4'd0) ? tx_cur[7] : tx_sr[7];
`else
    assign dev_ok = (rx_byte[7:1] == DEV_ADDR) && !rx_byte[0];

    // The register file has no read port in this build; fold it to one bit.
    always_comb begin
        unused_regfile = 1'b0;
        for (int i = 0; i < 16; i++) begin
            unused_regfile = unused_regfile ^ (^regfile[i]);
        end
    end
`endif

    assign busy       = (state != ST_IDLE);
    assign state_test = state;

    // State register.
    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes; START/STOP override bit edges.
    always_comb begin
        state_next  = state;
        oe_next     = sda_oe;
        cnt_clr     = 1'b0;
        rx_shift    = 1'b0;
        phase_set   = 1'b0;
        phase_clr   = 1'b0;
        wr_fire     = 1'b0;
        ptr_hi_load = 1'b0;
        ptr_lo_load = 1'b0;
`ifdef SCCB_READ_EN
        tx_step     = 1'b0;
        ptr_inc     = 1'b0;
`endif
        if (start_det) begin
            state_next = ST_DEV;
            oe_next    = 1'b0;
            cnt_clr    = 1'b1;
            phase_clr  = 1'b1;
        end else if (stop_det) begin
            state_next = ST_IDLE;
            oe_next    = 1'b0;
            cnt_clr    = 1'b1;
            phase_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_IGNORE: begin
                    oe_next = 1'b0;
                end
                ST_DEV: begin
                    if (scl_rise) begin
                        rx_shift = 1'b1;
                        if (byte_last) begin
                            state_next = dev_ok ? ST_DEV_ACK : ST_IGNORE;
                        end
                    end
                end
                ST_ADDRH: begin
                    if (scl_rise) begin
                        rx_shift = 1'b1;
                        if (byte_last) begin
                            ptr_hi_load = 1'b1;
                            state_next  = ST_ADDRH_ACK;
                        end
                    end
                end
                ST_ADDRL: begin
                    if (scl_rise) begin
                        rx_shift = 1'b1;
                        if (byte_last) begin
                            ptr_lo_load = 1'b1;
                            state_next  = ST_ADDRL_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        rx_shift = 1'b1;
                        if (byte_last) begin
                            state_next = ST_WDATA_ACK;
                        end
                    end
                end
                ST_DEV_ACK, ST_ADDRH_ACK, ST_ADDRL_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            oe_next   = 1'b1;
                            phase_set = 1'b1;
                            wr_fire   = (state == ST_WDATA_ACK);
                        end else begin
                            oe_next   = 1'b0;
                            phase_clr = 1'b1;
                            case (state)
                                ST_DEV_ACK:   state_next = ST_ADDRH;
                                ST_ADDRH_ACK: state_next = ST_ADDRL;
                                default:      state_next = ST_WDATA;
                            endcase
`ifdef SCCB_READ_EN
                            if (state == ST_DEV_ACK && rw_bit) begin
                                state_next = ST_RDATA;
                                tx_step    = 1'b1;
                                oe_next    = ~tx_bit;
                            end
`endif
                        end
                    end
                end
`ifdef SCCB_READ_EN
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_next    = 1'b0;
                            cnt_clr    = 1'b1;
                            state_next = ST_RD_ACK;
                        end else begin
                            tx_step = 1'b1;
                            oe_next = ~tx_bit;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_inc    = 1'b1;
                            state_next = ST_RDATA;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    oe_next    = 1'b0;
                end
            endcase
        end
    end

    // Datapath: bit counter, shifters, pointer, write strobe and register file.
    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            sda_oe    <= 1'b0;
            ack_phase <= 1'b0;
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            ptr       <= 16'h0000;
            wr_valid  <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                regfile[i] <= 8'h00;
            end
`ifdef SCCB_READ_EN
            rw_bit    <= 1'b0;
            tx_sr     <= 8'h00;
`endif
        end else begin
            sda_oe   <= oe_next;
            wr_valid <= 1'b0;

            if (phase_clr) begin
                ack_phase <= 1'b0;
            end else if (phase_set) begin
                ack_phase <= 1'b1;
            end

            if (cnt_clr) begin
                bit_cnt <= 4'd0;
            end else if (rx_shift) begin
                bit_cnt <= byte_last ? 4'd0 : bit_cnt + 4'd1;
`ifdef SCCB_READ_EN
            end else if (tx_step) begin
                bit_cnt <= bit_cnt + 4'd1;
`endif
            end

            if (rx_shift) begin
                rx_sr <= rx_byte;
            end
            if (ptr_hi_load) begin
                ptr[15:8] <= rx_byte;
            end
            if (ptr_lo_load) begin
                ptr[7:0] <= rx_byte;
            end

            if (wr_fire) begin
                wr_valid            <= 1'b1;
                wr_addr             <= ptr;
                wr_data             <= rx_sr;
                regfile[ptr[3:0]]   <= rx_sr;
                ptr                 <= ptr + 16'd1;
            end

`ifdef SCCB_READ_EN
            if (ptr_inc) begin
                ptr <= ptr + 16'd1;
            end
            if (state == ST_DEV && rx_shift && byte_last) begin
                rw_bit <= rx_byte[0];
            end
            if (tx_step) begin
                tx_sr <= (bit_cnt == 4'd0) ? {tx_cur[6:0], 1'b0} : {tx_sr[6:0], 1'b0};
            end
`endif
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-banged SCCB initiator driving sccb_responder, with a
// transaction-level model of the register pointer and register file.
`timescale 1ns/1ps
module tb_sccb_responder;

    localparam logic [6:0] DEV      = 7'h3C;
    localparam int         Q        = 8;
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_IGNORE = 4'd11;

    logic        meg25 = 1'b0;
    logic        rst   = 1'b1;
    logic        scl   = 1'b1;
    logic        tb_low = 1'b0;
    wire         sda;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic [3:0]  state_test;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          checks_failed = 0;
    logic [23:0] wr_q[$];
    int          dut_low_cycles = 0;
    logic [7:0]  model_regs [16];
    logic [7:0]  tx_data [4];

    assign sda = tb_low ? 1'b0 : 1'bz;
    pullup (sda);

    sccb_responder #(.DEV_ADDR(DEV)) dut (
        .meg25      (meg25),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .state_test (state_test)
    );

    // 25 MHz system clock.
    always #20 meg25 = ~meg25;

    // Record every write pulse and every cycle the responder holds sda low.
    always begin
        @(negedge meg25);
        #5;
        if (wr_valid === 1'b1) wr_q.push_back({wr_addr, wr_data});
        if (sda === 1'b0 && !tb_low) dut_low_cycles++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge meg25);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendStart();
        tb_low = 1'b0; waitCycles(Q);
        scl = 1'b1;    waitCycles(Q);
        tb_low = 1'b1; waitCycles(Q);
        scl = 1'b0;    waitCycles(Q);
    endtask

    task automatic sendStop();
        tb_low = 1'b1; waitCycles(Q);
        scl = 1'b1;    waitCycles(Q);
        tb_low = 1'b0; waitCycles(Q);
    endtask

    task automatic busIdle();
        tb_low = 1'b0; waitCycles(Q);
        scl = 1'b1;    waitCycles(Q);
    endtask

    task automatic sendBit(input logic b);
        tb_low = ~b; waitCycles(Q);
        scl = 1'b1;  waitCycles(2 * Q);
        scl = 1'b0;  waitCycles(Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        tb_low = 1'b0; waitCycles(Q);
        scl = 1'b1;    waitCycles(Q);
        ack = (sda === 1'b0);
        waitCycles(Q);
        scl = 1'b0;    waitCycles(Q);
    endtask

    task automatic readByte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            tb_low = 1'b0; waitCycles(Q);
            scl = 1'b1;    waitCycles(Q);
            b[i] = (sda !== 1'b0);
            waitCycles(Q);
            scl = 1'b0;    waitCycles(Q);
        end
        sendBit(nack);
        tb_low = 1'b0;
    endtask

    // One write transaction: device byte, two address bytes, ndata bytes of tx_data.
    task automatic applyStimulus(input string tag, input logic [7:0] dev, input logic [15:0] addr, input int ndata);
        logic        ack;
        logic        exp_ack;
        int          wr_base;
        int          low_base;
        logic [15:0] p;
        wr_base  = wr_q.size();
        low_base = dut_low_cycles;
        exp_ack  = (dev[7:1] == DEV) && !dev[0];
        sendStart();
        writeByte(dev, ack);
        checkOutput({tag, " dev ack"}, ack, exp_ack);
        if (!exp_ack) checkOutput({tag, " ignore state"}, state_test, S_IGNORE);
        writeByte(addr[15:8], ack);
        checkOutput({tag, " addrh ack"}, ack, exp_ack);
        writeByte(addr[7:0], ack);
        checkOutput({tag, " addrl ack"}, ack, exp_ack);
        for (int i = 0; i < ndata; i++) begin
            writeByte(tx_data[i], ack);
            checkOutput({tag, " data ack"}, ack, exp_ack);
        end
        checkOutput({tag, " busy mid"}, busy, 1'b1);
        sendStop();
        waitCycles(4);
        checkOutput({tag, " busy after stop"}, busy, 1'b0);
        checkOutput({tag, " idle after stop"}, state_test, S_IDLE);
        checkOutput({tag, " write count"}, wr_q.size() - wr_base, exp_ack ? ndata : 0);
        if (exp_ack) begin
            p = addr;
            for (int i = 0; i < ndata; i++) begin
                if (wr_base + i < wr_q.size())
                    checkOutput({tag, " write"}, wr_q[wr_base + i], {p, tx_data[i]});
                model_regs[p[3:0]] = tx_data[i];
                p = p + 16'd1;
            end
        end else begin
            checkOutput({tag, " sda never low"}, dut_low_cycles - low_base, 0);
        end
    endtask

`ifdef SCCB_READ_EN
    // Read nbytes starting at the pointer; optionally set the pointer first.
    task automatic runRead(input string tag, input logic set_addr, input logic [15:0] addr, input int nbytes);
        logic        ack;
        logic [7:0]  b;
        logic [15:0] p;
        if (set_addr) begin
            sendStart();
            writeByte({DEV, 1'b0}, ack);
            checkOutput({tag, " dev ack"}, ack, 1'b1);
            writeByte(addr[15:8], ack);
            writeByte(addr[7:0], ack);
        end
        sendStart();
        writeByte({DEV, 1'b1}, ack);
        checkOutput({tag, " read dev ack"}, ack, 1'b1);
        p = addr;
        for (int i = 0; i < nbytes; i++) begin
            readByte(i == nbytes - 1, b);
            checkOutput({tag, " read byte"}, b, model_regs[p[3:0]]);
            p = p + 16'd1;
        end
        checkOutput({tag, " ignore after nack"}, state_test, S_IGNORE);
        sendStop();
        waitCycles(4);
        checkOutput({tag, " busy after stop"}, busy, 1'b0);
    endtask
`endif

    // Directed scenarios followed by randomized writes.
    initial begin
        logic        ack;
        int          wr_base;
        int          low_base;
        logic [7:0]  rdev;
        logic [15:0] raddr;
        int          rn;

        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

        waitCycles(3);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset state", state_test, S_IDLE);
        checkOutput("reset wr_valid", wr_valid, 1'b0);
        checkOutput("reset wr_addr", wr_addr, 16'h0000);
        checkOutput("reset wr_data", wr_data, 8'h00);
        checkOutput("reset sda", sda, 1'b1);
        rst = 1'b0;
        waitCycles(Q);

        $display("[TB] single write 0x3008 <- 0x82");
        tx_data[0] = 8'h82;
        applyStimulus("req027", 8'h78, 16'h3008, 1);

        $display("[TB] sequential write 0x120F");
        tx_data[0] = 8'hAA; tx_data[1] = 8'hBB;
        applyStimulus("req028", 8'h78, 16'h120F, 2);

        $display("[TB] foreign device address");
        wr_base  = wr_q.size();
        low_base = dut_low_cycles;
        sendStart();
        writeByte(8'h7A, ack);
        checkOutput("req029 dev nack", ack, 1'b0);
        checkOutput("req029 ignore", state_test, S_IGNORE);
        writeByte(8'h30, ack);
        checkOutput("req029 byte nack", ack, 1'b0);
        checkOutput("req029 still ignore", state_test, S_IGNORE);
        sendStop();
        waitCycles(4);
        checkOutput("req029 idle", state_test, S_IDLE);
        checkOutput("req029 sda never low", dut_low_cycles - low_base, 0);
        checkOutput("req029 no writes", wr_q.size() - wr_base, 0);

        $display("[TB] pointer wrap at 0xFFFF");
        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
        applyStimulus("wrap", 8'h78, 16'hFFFF, 3);

        $display("[TB] repeated start abandons partial transaction");
        sendStart();
        writeByte(8'h78, ack);
        writeByte(8'h12, ack);
        tx_data[0] = 8'hCC;
        applyStimulus("rstart", 8'h78, 16'h0005, 1);

        $display("[TB] address-only transaction");
        applyStimulus("addr only", 8'h78, 16'h0003, 0);

`ifdef SCCB_READ_EN
        $display("[TB] read back");
        tx_data[0] = 8'h55;
        applyStimulus("read setup", 8'h78, 16'h0003, 1);
        runRead("req030", 1'b1, 16'h0003, 1);
        applyStimulus("addr only 2", 8'h78, 16'h000F, 0);
        runRead("ptr only", 1'b0, 16'h000F, 3);
`else
        $display("[TB] read request without read support");
        low_base = dut_low_cycles;
        sendStart();
        writeByte(8'h79, ack);
        checkOutput("read nack", ack, 1'b0);
        checkOutput("read ignore", state_test, S_IGNORE);
        sendStop();
        waitCycles(4);
        checkOutput("read idle", state_test, S_IDLE);
        checkOutput("read sda never low", dut_low_cycles - low_base, 0);
`endif

        $display("[TB] reset during address low byte");
        sendStart();
        writeByte(8'h78, ack);
        writeByte(8'h30, ack);
        wr_base = wr_q.size();
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b0);
        tb_low = 1'b0;
        waitCycles(1);
        rst = 1'b1;
        #1;
        checkOutput("rst addrl state", state_test, S_IDLE);
        checkOutput("rst addrl busy", busy, 1'b0);
        checkOutput("rst addrl sda", sda, 1'b1);
        waitCycles(2);
        rst = 1'b0;
        busIdle();
        checkOutput("rst addrl no write", wr_q.size() - wr_base, 0);

        $display("[TB] reset while acknowledging");
        sendStart();
        writeByte(8'h78, ack);
        writeByte(8'h30, ack);
        for (int i = 7; i >= 0; i--) sendBit(1'b0);
        tb_low = 1'b0;
        waitCycles(1);
        checkOutput("ack held low", sda, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst ack sda", sda, 1'b1);
        checkOutput("rst ack wr_valid", wr_valid, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        busIdle();
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        tx_data[0] = 8'h82;
        applyStimulus("req031", 8'h78, 16'h3008, 1);

        $display("[TB] randomized writes");
        for (int t = 0; t < 6; t++) begin
            rdev = 8'h78;
            if ($urandom_range(0, 3) == 0) begin
                rdev = 8'($urandom);
                if (rdev[7:1] == DEV) rdev[7:1] = 7'h3D;
            end
            raddr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) raddr = 16'hFFFE + 16'($urandom_range(0, 1));
            rn = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
            applyStimulus("rand", rdev, raddr, rn);
        end

`ifdef SCCB_READ_EN
        runRead("rand readback", 1'b1, 16'h0000, 4);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
